entrada_jogada: RTL and testbench

Upstream input stage of the tic-tac-toe core: turns nine raw, bouncing cell buttons into clean single-cycle move strobes on the `posicao[0:8]` bus consumed by `game`. It synchronises and debounces each button, accepts a move only when exactly one cell is pressed, and rejects occupied cells or moves made after the game has ended. It re-arms only after every button has been released.

---
 rtl/entrada_jogada_pkg.sv | 43 ++++
 rtl/entrada_jogada_debouncer.sv | 63 ++++++
 rtl/entrada_jogada.sv | 106 ++++++++++
 tb/tb_entrada_jogada.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/entrada_jogada_pkg.sv
// ============================================================================
// Module      : entrada_jogada_pkg
// Description : Shared types and constants for the tic-tac-toe input stage:
//               FSM state encoding, cell indices (row-major, 0 = top-left)
//               and a small popcount helper for the one-hot check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package entrada_jogada_pkg;

  // Two-bit FSM encoding; 2'b10 and 2'b11 are unused and recover to IDLE.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_REL = 2'b01
  } state_t;

  localparam int C_N_CELLS = 9;

  // Cell indices shared with the game core so both agree on bit ordering.
  localparam int C_CELL_0 = 0;
  localparam int C_CELL_1 = 1;
  localparam int C_CELL_2 = 2;
  localparam int C_CELL_3 = 3;
  localparam int C_CELL_4 = 4;
  localparam int C_CELL_5 = 5;
  localparam int C_CELL_6 = 6;
  localparam int C_CELL_7 = 7;
  localparam int C_CELL_8 = 8;

  // Number of set bits across the nine debounced cells.
  function automatic logic [3:0] popcount9(input logic [0:8] v);
    logic [3:0] acc;
    acc = 4'd0;
    for (int i = 0; i < C_N_CELLS; i++) begin
      acc = acc + {3'b000, v[i]};
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/entrada_jogada_debouncer.sv
// ============================================================================
// Module      : debouncer
// Description : One-bit two-flop synchroniser followed by a counting
//               debouncer. The stable output only changes after the
//               synchronised input has differed from it for DEBOUNCE_CYCLES
//               consecutive edges; any agreeing sample restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic estavel
);

  import entrada_jogada_pkg::*;

  // Counter value on which the pending level is finally accepted.
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= botao;
      r_s2 <= r_s1;
    end
  end

  // Count disagreeing samples; accept the new level after a full run.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (r_s2 != r_deb) begin
      if (r_cnt == C_LAST) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign estavel = r_deb;

endmodule

`default_nettype wire

// File: rtl/entrada_jogada.sv
// ============================================================================
// Module      : entrada_jogada
// Description : Input stage of the tic-tac-toe core. Debounces the nine cell
//               buttons, accepts a move only when exactly one free cell is
//               pressed and the game is still running, and emits one-cycle
//               move strobes or error pulses. Re-arms only once every button
//               has been released.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module entrada_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [0:8] botoes,
  input  logic [0:8] ocupadas,
  input  logic       fim_jogo,
  output logic [0:8] posicao,
  output logic       erro,
  output logic       ocioso
);

  import entrada_jogada_pkg::*;

  logic [0:8] w_deb;
  logic       w_um_so;
  logic       w_livre;

  state_t     r_state;
  logic [0:8] r_posicao;
  logic       r_erro;
  logic       r_ocioso;

  genvar gi;
  generate
    for (gi = 0; gi < C_N_CELLS; gi++) begin : g_debounce
      debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debouncer (
        .clock  (clock),
        .reset  (reset),
        .botao  (botoes[gi]),
        .estavel(w_deb[gi])
      );
    end
  endgenerate

  // Exactly one debounced cell pressed, and that cell is not yet taken.
  assign w_um_so = (popcount9(w_deb) == 4'd1);
  assign w_livre = ((w_deb & ocupadas) == 9'b0);

  // Move-acceptance FSM with registered strobe, error and idle outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_posicao <= '0;
      r_erro    <= 1'b0;
      r_ocioso  <= 1'b1;
    end else begin
      r_posicao <= '0;
      r_erro    <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((w_deb == 9'b0) || fim_jogo) begin
            // Nothing pressed, or game over: presses are ignored outright.
            r_state  <= IDLE;
            r_ocioso <= 1'b1;
          end else if (w_um_so && w_livre) begin
            r_posicao <= w_deb;
            r_state   <= WAIT_REL;
            r_ocioso  <= 1'b0;
          end else begin
            // Multi-press or occupied cell.
            r_erro   <= 1'b1;
            r_state  <= WAIT_REL;
            r_ocioso <= 1'b0;
          end
        end
        WAIT_REL: begin
          if (w_deb == 9'b0) begin
            r_state  <= IDLE;
            r_ocioso <= 1'b1;
          end else begin
            r_state  <= WAIT_REL;
            r_ocioso <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ocioso <= 1'b1;
        end
      endcase
    end
  end

  assign posicao = r_posicao;
  assign erro    = r_erro;
  assign ocioso  = r_ocioso;

endmodule

`default_nettype wire

// File: tb/tb_entrada_jogada.sv
// ============================================================================
// Module      : tb_entrada_jogada
// Description : Directed self-checking bench for entrada_jogada with
//               DEBOUNCE_CYCLES = 4 (press-to-strobe latency of 7 edges).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_entrada_jogada;

  logic       clock;
  logic       reset;
  logic [0:8] botoes;
  logic [0:8] ocupadas;
  logic       fim_jogo;
  logic [0:8] posicao;
  logic       erro;
  logic       ocioso;

  int n_compared;
  int n_mismatched;
  int n_pos;
  int n_err;
  int n_both;
  logic [0:8] last_pos;

  localparam logic [0:8] C_C0 = 9'b100000000;
  localparam logic [0:8] C_C1 = 9'b010000000;
  localparam logic [0:8] C_C2 = 9'b001000000;
  localparam logic [0:8] C_C3 = 9'b000100000;
  localparam logic [0:8] C_C4 = 9'b000010000;
  localparam logic [0:8] C_C5 = 9'b000001000;
  localparam logic [0:8] C_C7 = 9'b000000010;
  localparam logic [0:8] C_C8 = 9'b000000001;

  entrada_jogada #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .botoes  (botoes),
    .ocupadas(ocupadas),
    .fim_jogo(fim_jogo),
    .posicao (posicao),
    .erro    (erro),
    .ocioso  (ocioso)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n edges; sample 1 ns after each edge and tally pulses.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      if (posicao != 9'b0) begin
        n_pos++;
        last_pos = posicao;
      end
      if (erro) n_err++;
      if (erro && (posicao != 9'b0)) n_both++;
    end
  endtask

  task automatic clear_counts();
    n_pos = 0;
    n_err = 0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    n_both       = 0;
    last_pos     = '0;
    clear_counts();
    reset    = 1'b0;
    botoes   = '0;
    ocupadas = '0;
    fim_jogo = 1'b0;

    // Reset state
    tick(3);
    check("rst_posicao", 32'(posicao), 32'h0);
    check("rst_erro",    32'(erro),    32'h0);
    check("rst_ocioso",  32'(ocioso),  32'h1);
    reset = 1'b1;
    tick(2);

    // Clean press of cell 4
    clear_counts();
    botoes = C_C4;
    tick(6);
    check("clean_early",   32'(posicao), 32'h0);
    check("clean_idle_pre", 32'(ocioso), 32'h1);
    tick(1);
    check("clean_strobe",  32'(posicao), 32'(C_C4));
    check("clean_erro",    32'(erro),    32'h0);
    check("clean_ocioso",  32'(ocioso),  32'h0);
    tick(1);
    check("clean_one_cyc", 32'(posicao), 32'h0);
    botoes = '0;
    tick(8);
    check("clean_rearm",   32'(ocioso),  32'h1);
    check("clean_npos",    32'(n_pos),   32'd1);

    // Bounce on cell 0: 2 high, 1 low, then stable high
    clear_counts();
    botoes = C_C0;
    tick(2);
    botoes = '0;
    tick(1);
    botoes = C_C0;
    tick(6);
    check("bounce_early",  32'(n_pos),   32'd0);
    tick(1);
    check("bounce_strobe", 32'(posicao), 32'(C_C0));
    tick(20);
    check("bounce_npos",   32'(n_pos),   32'd1);
    check("bounce_nerr",   32'(n_err),   32'd0);
    botoes = '0;
    tick(10);

    // Occupied cell 2
    clear_counts();
    ocupadas = C_C2;
    botoes   = C_C2;
    tick(6);
    check("occ_early",  32'(erro),  32'h0);
    tick(1);
    check("occ_erro",   32'(erro),  32'h1);
    tick(10);
    check("occ_nerr",   32'(n_err), 32'd1);
    check("occ_npos",   32'(n_pos), 32'd0);
    botoes = '0;
    tick(10);
    ocupadas = '0;

    // Game over: press on cell 3 ignored, FSM stays idle
    clear_counts();
    fim_jogo = 1'b1;
    botoes   = C_C3;
    tick(20);
    check("fim_npos",   32'(n_pos),  32'd0);
    check("fim_nerr",   32'(n_err),  32'd0);
    check("fim_ocioso", 32'(ocioso), 32'h1);
    botoes = '0;
    tick(10);
    fim_jogo = 1'b0;

    // Multi-press on cells 1 and 7
    clear_counts();
    botoes = C_C1 | C_C7;
    tick(6);
    check("multi_early",  32'(erro),   32'h0);
    tick(1);
    check("multi_erro",   32'(erro),   32'h1);
    botoes = C_C7;
    tick(20);
    check("multi_hold7",  32'(ocioso), 32'h0);
    check("multi_npos",   32'(n_pos),  32'd0);
    check("multi_nerr",   32'(n_err),  32'd1);
    botoes = '0;
    tick(10);
    check("multi_rearm",  32'(ocioso), 32'h1);
    botoes = C_C7;
    tick(7);
    check("multi_cell7",  32'(posicao), 32'(C_C7));
    botoes = '0;
    tick(10);

    // Hold cell 5 for 50 cycles, then re-arm
    clear_counts();
    botoes = C_C5;
    tick(50);
    check("hold_npos",    32'(n_pos),  32'd1);
    botoes = '0;
    tick(10);
    check("hold_between", 32'(ocioso), 32'h1);
    botoes = C_C5;
    tick(10);
    check("hold_npos2",   32'(n_pos),  32'd2);
    check("hold_last",    32'(last_pos), 32'(C_C5));
    botoes = '0;
    tick(10);

    // Reset while cell 8 held in WAIT_REL
    clear_counts();
    botoes = C_C8;
    tick(10);
    check("rmid_wait",    32'(ocioso),  32'h0);
    reset = 1'b0;
    tick(1);
    check("rmid_posicao", 32'(posicao), 32'h0);
    check("rmid_erro",    32'(erro),    32'h0);
    check("rmid_ocioso",  32'(ocioso),  32'h1);
    reset = 1'b1;
    clear_counts();
    tick(6);
    check("rmid_early",   32'(n_pos),   32'd0);
    tick(1);
    check("rmid_strobe",  32'(posicao), 32'(C_C8));
    botoes = '0;
    tick(10);

    check("never_both",   32'(n_both),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
